// File: rtl/unidade_controle.sv
// unidade_controle: multicycle FSM sequencing every enable and mux select of the 64-bit RISC-V datapath.
module unidade_controle (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       reset_wire,
    output logic [2:0] operacao,
    output logic       SELETOR_MUX_A,
    output logic [1:0] SELETOR_MUX_B,
    output logic       WRITE_PC,
    output logic       PC_SRC,
    output logic       WR_MEM_INSTR,
    output logic       LOAD_IR,
    output logic       LOAD_A,
    output logic       LOAD_B,
    output logic       LOAD_ALUOUT,
    output logic       LOAD_MDR,
    output logic       REG_WRITE,
    output logic       MEM_TO_REG,
    output logic       WR_MEM_DATA,
    output logic       ILLEGAL,
    output logic       HALTED,
    output logic [4:0] estado
);
    typedef enum logic [4:0] {
        RST_ST = 5'd0, FETCH = 5'd1, IR_LD = 5'd2, DECODE = 5'd3,
        EXEC_R = 5'd4, EXEC_I = 5'd5, WB_ALU = 5'd6, ADDR = 5'd7,
        MEM_RD = 5'd8, LD_MDR = 5'd9, WB_LD = 5'd10, MEM_WR = 5'd11,
        BRANCH = 5'd12, PC_INC = 5'd13, ILL = 5'd14, HALT = 5'd15
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011, ALU_XOR = 3'b100;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_SYS = 7'b1110011;

    state_t state, next;
    logic r_ok, b_ok, taken;
    logic [2:0] r_op;

    assign r_ok = funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b100;
    assign r_op = funct3 == 3'b000 ? (funct7_5 ? ALU_SUB : ALU_ADD) : funct3 == 3'b111 ? ALU_AND : ALU_XOR;
    assign b_ok = funct3[2:1] == 2'b00;
    // beq (000) takes on zero, bne (001) on !zero
    assign taken = b_ok && (zero != funct3[0]);
    assign WR_MEM_INSTR = 1'b0;
    assign estado = state;

    always_ff @(posedge CLK or negedge RST)
        if (!RST) state <= RST_ST;
        else state <= next;

    always_comb begin
        next = RST_ST;
        reset_wire = 1'b0;
        operacao = 3'b000;
        SELETOR_MUX_A = 1'b0;
        SELETOR_MUX_B = 2'b00;
        WRITE_PC = 1'b0;
        PC_SRC = 1'b0;
        LOAD_IR = 1'b0;
        LOAD_A = 1'b0;
        LOAD_B = 1'b0;
        LOAD_ALUOUT = 1'b0;
        LOAD_MDR = 1'b0;
        REG_WRITE = 1'b0;
        MEM_TO_REG = 1'b0;
        WR_MEM_DATA = 1'b0;
        ILLEGAL = 1'b0;
        HALTED = 1'b0;
        case (state)
            RST_ST: begin
                reset_wire = 1'b1;
                next = FETCH;
            end
            FETCH: next = IR_LD;
            IR_LD: begin
                LOAD_IR = 1'b1;
                next = DECODE;
            end
            // branch target PC + (imm << 1) lands in ALUOut while decoding
            DECODE: begin
                LOAD_A = 1'b1;
                LOAD_B = 1'b1;
                SELETOR_MUX_B = 2'b11;
                operacao = ALU_ADD;
                LOAD_ALUOUT = 1'b1;
                next = op_code == OP_R ? EXEC_R : op_code == OP_I ? EXEC_I :
                       (op_code == OP_LD || op_code == OP_ST) ? ADDR :
                       op_code == OP_BR ? BRANCH : op_code == OP_SYS ? HALT : ILL;
            end
            EXEC_R: begin
                SELETOR_MUX_A = 1'b1;
                operacao = r_ok ? r_op : 3'b000;
                LOAD_ALUOUT = r_ok;
                next = r_ok ? WB_ALU : ILL;
            end
            EXEC_I, ADDR: begin
                SELETOR_MUX_A = 1'b1;
                SELETOR_MUX_B = 2'b10;
                operacao = ALU_ADD;
                LOAD_ALUOUT = 1'b1;
                next = state == EXEC_I ? WB_ALU : op_code == OP_LD ? MEM_RD : MEM_WR;
            end
            WB_ALU: begin
                REG_WRITE = 1'b1;
                next = PC_INC;
            end
            MEM_RD: next = LD_MDR;
            LD_MDR: begin
                LOAD_MDR = 1'b1;
                next = WB_LD;
            end
            WB_LD: begin
                REG_WRITE = 1'b1;
                MEM_TO_REG = 1'b1;
                next = PC_INC;
            end
            MEM_WR: begin
                WR_MEM_DATA = 1'b1;
                next = PC_INC;
            end
            BRANCH: begin
                SELETOR_MUX_A = 1'b1;
                operacao = ALU_SUB;
                WRITE_PC = taken;
                PC_SRC = taken;
                next = !b_ok ? ILL : taken ? FETCH : PC_INC;
            end
            PC_INC: begin
                SELETOR_MUX_B = 2'b01;
                operacao = ALU_ADD;
                WRITE_PC = 1'b1;
                next = FETCH;
            end
            ILL: begin
                ILLEGAL = 1'b1;
                next = PC_INC;
            end
            HALT: begin
                HALTED = 1'b1;
                next = HALT;
            end
            default: next = RST_ST;
        endcase
    end
endmodule
